// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: sequencer in front of spi_shift_reg.
//  Takes one character per command (valid/ready), loads it into the shift
//  register, fires go, waits for tip to fall and returns the received character
//  (valid/ready). Owns slave-select framing with setup and gap timing.
// Ports:
//  wb_clk_in, wb_rst                  clock, async active-high reset
//  cmd_valid/ready/data/len/last      command channel (last closes the frame)
//  rsp_valid/ready/data/err           response channel (err = timeout abort)
//  ss_n                               slave select, active-low
//  sr_go/latch/byte_sel/p_in/len      drive to spi_shift_reg
//  sr_tip, sr_p_out                   status/data from spi_shift_reg
// Optional feature: define SPI_XFER_TIMEOUT_EN to enable the go-to-tip-end
//  timeout (TIMEOUT_CYCLES); otherwise rsp_err is tied 0 and GO/BUSY wait forever.

`ifndef SPI_MAX_CHAR
`define SPI_MAX_CHAR 128
`endif
`ifndef SPI_CHAR_LEN_BITS
`define SPI_CHAR_LEN_BITS 7
`endif

module spi_xfer_ctrl #(
  parameter int unsigned SS_SETUP = 2,
  parameter int unsigned SS_GAP   = 3
`ifdef SPI_XFER_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                          wb_clk_in,
  input  logic                          wb_rst,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [`SPI_MAX_CHAR-1:0]      cmd_data,
  input  logic [`SPI_CHAR_LEN_BITS-1:0] cmd_len,
  input  logic                          cmd_last,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [`SPI_MAX_CHAR-1:0]      rsp_data,
  output logic                          rsp_err,
  output logic                          ss_n,
  output logic                          sr_go,
  output logic [3:0]                    sr_latch,
  output logic [3:0]                    sr_byte_sel,
  output logic [`SPI_MAX_CHAR-1:0]      sr_p_in,
  output logic [`SPI_CHAR_LEN_BITS-1:0] sr_len,
  input  logic                          sr_tip,
  input  logic [`SPI_MAX_CHAR-1:0]      sr_p_out
);

  localparam int unsigned CW     = `SPI_MAX_CHAR;
  localparam int unsigned LW     = `SPI_CHAR_LEN_BITS;
  localparam int unsigned SG_MAX = (SS_SETUP > SS_GAP) ? SS_SETUP : SS_GAP;
  localparam int unsigned SG_W   = $clog2(SG_MAX + 1);
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int unsigned TO_W   = $clog2(TIMEOUT_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SETUP, S_GO, S_BUSY, S_CAPT, S_RSP, S_GAP
  } state_t;

  state_t          r_state, w_state_nxt;
  logic            r_cmd_ready, w_cmd_ready_nxt;
  logic            r_ss_n, w_ss_n_nxt;
  logic            r_sr_go, w_sr_go_nxt;
  logic            r_sr_load, w_sr_load_nxt;
  logic [CW-1:0]   r_sr_p_in, w_sr_p_in_nxt;
  logic [LW-1:0]   r_sr_len, w_sr_len_nxt;
  logic            r_last, w_last_nxt;
  logic            r_mid, w_mid_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [CW-1:0]   r_rsp_data, w_rsp_data_nxt;
  logic [SG_W-1:0] r_cnt, w_cnt_nxt;
  logic            w_close;
`ifdef SPI_XFER_TIMEOUT_EN
  logic            r_rsp_err, w_rsp_err_nxt;
  logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;

  // A timed-out transfer always closes the frame.
  assign w_close = r_last | r_rsp_err;
`else
  assign w_close = r_last;
`endif

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cmd_ready_nxt = 1'b0;
    w_ss_n_nxt      = r_ss_n;
    w_sr_go_nxt     = 1'b0;
    w_sr_load_nxt   = 1'b0;
    w_sr_p_in_nxt   = r_sr_p_in;
    w_sr_len_nxt    = r_sr_len;
    w_last_nxt      = r_last;
    w_mid_nxt       = r_mid;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_data_nxt  = r_rsp_data;
    w_cnt_nxt       = r_cnt;
`ifdef SPI_XFER_TIMEOUT_EN
    w_rsp_err_nxt   = r_rsp_err;
    w_to_cnt_nxt    = r_to_cnt;
`endif
    unique case (r_state)
      S_IDLE: begin
        w_cmd_ready_nxt = 1'b1;
        if (cmd_valid && r_cmd_ready) begin
          w_state_nxt     = S_LOAD;
          w_cmd_ready_nxt = 1'b0;
          w_mid_nxt       = ~r_ss_n;  // ss_n already low: frame continues
          w_ss_n_nxt      = 1'b0;
          w_sr_load_nxt   = 1'b1;
          w_sr_p_in_nxt   = cmd_data;
          w_sr_len_nxt    = cmd_len;
          w_last_nxt      = cmd_last;
        end
      end
      S_LOAD: begin
        w_cnt_nxt = '0;
        if (r_mid) begin
          w_state_nxt = S_GO;
          w_sr_go_nxt = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end else begin
          w_state_nxt = S_SETUP;
        end
      end
      S_SETUP: begin
        if (r_cnt == SG_W'(SS_SETUP - 1)) begin
          w_state_nxt = S_GO;
          w_sr_go_nxt = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
          w_to_cnt_nxt = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + SG_W'(1);
        end
      end
      S_GO: begin
        if (sr_tip) w_state_nxt = S_BUSY;
        else        w_sr_go_nxt = 1'b1;
      end
      S_BUSY: begin
        if (!sr_tip) w_state_nxt = S_CAPT;
      end
      S_CAPT: begin
        w_state_nxt     = S_RSP;
        w_rsp_data_nxt  = sr_p_out;
        w_rsp_valid_nxt = 1'b1;
`ifdef SPI_XFER_TIMEOUT_EN
        w_rsp_err_nxt   = 1'b0;
`endif
      end
      S_RSP: begin
        if (rsp_ready) begin
          w_rsp_valid_nxt = 1'b0;
          if (w_close) begin
            w_state_nxt = S_GAP;
            w_ss_n_nxt  = 1'b1;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt     = S_IDLE;
            w_cmd_ready_nxt = 1'b1;
          end
        end
      end
      S_GAP: begin
        if (r_cnt == SG_W'(SS_GAP - 1)) begin
          w_state_nxt     = S_IDLE;
          w_cmd_ready_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + SG_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
`ifdef SPI_XFER_TIMEOUT_EN
    // Abort when the shift register has not finished within the limit.
    if (r_state == S_GO || r_state == S_BUSY) begin
      if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        w_state_nxt     = S_RSP;
        w_sr_go_nxt     = 1'b0;
        w_ss_n_nxt      = 1'b1;
        w_rsp_data_nxt  = '0;
        w_rsp_err_nxt   = 1'b1;
        w_rsp_valid_nxt = 1'b1;
      end else begin
        w_to_cnt_nxt = r_to_cnt + TO_W'(1);
      end
    end
`endif
  end

  // State and output registers.
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_ss_n      <= 1'b1;
      r_sr_go     <= 1'b0;
      r_sr_load   <= 1'b0;
      r_sr_p_in   <= '0;
      r_sr_len    <= '0;
      r_last      <= 1'b0;
      r_mid       <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_cnt       <= '0;
`ifdef SPI_XFER_TIMEOUT_EN
      r_rsp_err   <= 1'b0;
      r_to_cnt    <= '0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= w_cmd_ready_nxt;
      r_ss_n      <= w_ss_n_nxt;
      r_sr_go     <= w_sr_go_nxt;
      r_sr_load   <= w_sr_load_nxt;
      r_sr_p_in   <= w_sr_p_in_nxt;
      r_sr_len    <= w_sr_len_nxt;
      r_last      <= w_last_nxt;
      r_mid       <= w_mid_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
      r_cnt       <= w_cnt_nxt;
`ifdef SPI_XFER_TIMEOUT_EN
      r_rsp_err   <= w_rsp_err_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
`endif
    end
  end

  assign cmd_ready   = r_cmd_ready;
  assign ss_n        = r_ss_n;
  assign sr_go       = r_sr_go;
  assign sr_latch    = {4{r_sr_load}};
  assign sr_byte_sel = {4{r_sr_load}};
  assign sr_p_in     = r_sr_p_in;
  assign sr_len      = r_sr_len;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
`ifdef SPI_XFER_TIMEOUT_EN
  assign rsp_err     = r_rsp_err;
`else
  assign rsp_err     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: directed scenarios plus randomized commands against
// a transaction-level expectation (frame state, latency formula, echoed data).

`ifndef SPI_MAX_CHAR
`define SPI_MAX_CHAR 128
`endif
`ifndef SPI_CHAR_LEN_BITS
`define SPI_CHAR_LEN_BITS 7
`endif

module tb_spi_xfer_ctrl;

  localparam int unsigned CW    = `SPI_MAX_CHAR;
  localparam int unsigned LW    = `SPI_CHAR_LEN_BITS;
  localparam int unsigned SETUP = 2;
  localparam int unsigned GAP   = 3;
`ifdef SPI_XFER_TIMEOUT_EN
  localparam int unsigned TO    = 16;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_data = '0;
  logic [LW-1:0] cmd_len = '0;
  logic          cmd_last = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [CW-1:0] rsp_data;
  logic          rsp_err;
  logic          ss_n;
  logic          sr_go;
  logic [3:0]    sr_latch;
  logic [3:0]    sr_byte_sel;
  logic [CW-1:0] sr_p_in;
  logic [LW-1:0] sr_len;
  logic          tip = 1'b0;
  logic [CW-1:0] p_out = '0;

  int n_total = 0;
  int n_bad   = 0;

  // Peer shift-register model controls.
  bit            slave_en = 1'b1;
  int            slave_t = 1;
  logic [CW-1:0] slave_resp = '0;
  int            s_phase = 0;
  int            s_rem = 0;
  bit            frame_closed = 1'b1;

  always #5 clk = ~clk;

  spi_xfer_ctrl #(
    .SS_SETUP(SETUP),
    .SS_GAP(GAP)
`ifdef SPI_XFER_TIMEOUT_EN
    , .TIMEOUT_CYCLES(TO)
`endif
  ) u_dut (
    .wb_clk_in(clk), .wb_rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .cmd_len(cmd_len), .cmd_last(cmd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .ss_n(ss_n), .sr_go(sr_go), .sr_latch(sr_latch),
    .sr_byte_sel(sr_byte_sel), .sr_p_in(sr_p_in), .sr_len(sr_len),
    .sr_tip(tip), .sr_p_out(p_out)
  );

  // Shift register peer: sees go, raises tip one cycle later for slave_t cycles,
  // then presents slave_resp on p_out as tip falls.
  always @(negedge clk) begin
    if (rst) begin
      tip = 1'b0;
      s_phase = 0;
      s_rem = 0;
    end else begin
      case (s_phase)
        0: if (sr_go === 1'b1 && slave_en) s_phase = 1;
        1: begin tip = 1'b1; s_rem = slave_t; s_phase = 2; end
        default: begin
          s_rem = s_rem - 1;
          if (s_rem <= 0) begin
            tip = 1'b0;
            p_out = slave_resp;
            s_phase = 0;
          end
        end
      endcase
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CW-1:0] rnd_char();
    logic [127:0] v;
    v = {$urandom(), $urandom(), $urandom(), $urandom()};
    return CW'(v);
  endfunction

  // Present a command at a negedge, return at the negedge after acceptance.
  task automatic send_cmd(input logic [CW-1:0] data, input logic [LW-1:0] len, input logic last);
    int w;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 60) begin @(negedge clk); w++; end
    chk("cmd_ready_before_accept", cmd_ready, 1'b1);
    cmd_valid = 1'b1;
    cmd_data  = data;
    cmd_len   = len;
    cmd_last  = last;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_data  = rnd_char();
    cmd_len   = LW'($urandom_range(0, 127));
    cmd_last  = 1'($urandom_range(0, 1));
  endtask

  // Full transaction with expectations derived from the frame state and the
  // accept-to-response latency rule (4 + setup on a new frame + tip cycles).
  task automatic xfer(input logic [CW-1:0] data, input logic [LW-1:0] len, input logic last,
                      input int tlen, input logic [CW-1:0] resp, input int hold,
                      input bit early, input bit poke);
    int t, go_t, rv_t, ss_bad, latch_bad, stable_bad, gap_n;
    bit newf;
    logic [CW-1:0] held;
    newf = frame_closed;
    slave_en = 1'b1;
    slave_t = tlen;
    slave_resp = resp;
    send_cmd(data, len, last);
    if (early) rsp_ready = 1'b1;
    t = 0; go_t = -1; rv_t = -1; ss_bad = 0; latch_bad = 0; stable_bad = 0;
    while (rv_t < 0 && t < 300) begin
      if (t == 0) begin
        chk("load_latch", sr_latch, 4'hF);
        chk("load_byte_sel", sr_byte_sel, 4'hF);
        chk("load_p_in", sr_p_in, data);
        chk("load_len", sr_len, len);
      end else if (sr_latch !== 4'h0 || sr_byte_sel !== 4'h0) begin
        latch_bad++;
      end
      if (go_t < 0 && sr_go === 1'b1) go_t = t;
      if (ss_n !== 1'b0) ss_bad++;
      if (rsp_valid === 1'b1) begin
        rv_t = t;
      end else begin
        if (poke) begin
          cmd_valid = (go_t >= 0 && t > go_t + 1);
          cmd_data  = rnd_char();
          cmd_len   = LW'(9);
        end
        @(negedge clk);
        t++;
      end
    end
    cmd_valid = 1'b0;
    chk("go_time", 128'(go_t), 128'(newf ? 1 + SETUP : 1));
    chk("rsp_latency", 128'(rv_t), 128'(newf ? 4 + SETUP + tlen : 4 + tlen));
    chk("ss_low_in_xfer", 128'(ss_bad), 128'(0));
    chk("no_reload", 128'(latch_bad), 128'(0));
    chk("rsp_data", rsp_data, resp);
    chk("rsp_err", rsp_err, 1'b0);
    if (poke) begin
      chk("poke_len_kept", sr_len, len);
      chk("poke_p_in_kept", sr_p_in, data);
    end
    held = rsp_data;
    if (!early) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        if (rsp_valid !== 1'b1 || rsp_data !== held || cmd_ready !== 1'b0) stable_bad++;
      end
      if (hold > 0) chk("rsp_stable", 128'(stable_bad), 128'(0));
      rsp_ready = 1'b1;
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_drop", rsp_valid, 1'b0);
    if (last) begin
      gap_n = 0; ss_bad = 0;
      while (cmd_ready !== 1'b1 && gap_n < 50) begin
        if (ss_n !== 1'b1) ss_bad++;
        gap_n++;
        @(negedge clk);
      end
      chk("gap_cycles", 128'(gap_n), 128'(GAP));
      chk("gap_ss_high", 128'(ss_bad), 128'(0));
      chk("idle_ss_high", ss_n, 1'b1);
      frame_closed = 1'b1;
    end else begin
      chk("midframe_ready", cmd_ready, 1'b1);
      chk("midframe_ss_low", ss_n, 1'b0);
      frame_closed = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_ss_n", ss_n, 1'b1);
    chk("rst_sr_go", sr_go, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    frame_closed = 1'b1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : main
    int w, go_t, rv_t;
    // Reset values.
    @(negedge clk);
    chk("reset_cmd_ready", cmd_ready, 1'b0);
    chk("reset_ss_n", ss_n, 1'b1);
    chk("reset_sr_go", sr_go, 1'b0);
    chk("reset_rsp_valid", rsp_valid, 1'b0);
    chk("reset_rsp_data", rsp_data, '0);
    chk("reset_rsp_err", rsp_err, 1'b0);
    chk("reset_latch", {sr_latch, sr_byte_sel}, 8'h00);
    chk("reset_p_in", sr_p_in, '0);
    chk("reset_len", sr_len, '0);
    rst = 1'b0;
    @(negedge clk);
    chk("first_idle_ready", cmd_ready, 1'b1);

    // Single-character frame with a fixed echo.
    xfer(CW'(16'hAA55), LW'(0), 1'b1, 3, CW'(16'h1234), 0, 1'b0, 1'b0);

    // Three-character frame: one setup, ss_n low throughout.
    xfer(CW'(16'h0101), LW'(8), 1'b0, 2, CW'(16'hBEEF), 0, 1'b0, 1'b0);
    xfer(CW'(16'h0202), LW'(16), 1'b0, 4, CW'(16'hCAFE), 0, 1'b1, 1'b0);
    xfer(CW'(16'h0303), LW'(24), 1'b1, 1, CW'(16'hF00D), 0, 1'b0, 1'b0);

    // Response back-pressure for 10 cycles.
    xfer(CW'(32'h5A5A_A5A5), LW'(32), 1'b1, 2, CW'(32'h1357_9BDF), 10, 1'b0, 1'b0);

    // cmd_valid pulsed during BUSY is ignored; len 4 reaches the shift register.
    xfer(CW'(8'h0F), LW'(4), 1'b1, 5, CW'(8'h0A), 2, 1'b0, 1'b1);

    // Reset in the middle of BUSY.
    slave_en = 1'b1;
    slave_t = 20;
    slave_resp = CW'(16'hDEAD);
    send_cmd(CW'(16'h7777), LW'(16), 1'b1);
    w = 0;
    while (!(tip === 1'b1 && sr_go === 1'b0) && w < 50) begin @(negedge clk); w++; end
    chk("reached_busy", 128'(w < 50), 128'(1));
    do_reset();

    // Tip never rises.
    slave_en = 1'b0;
    send_cmd(CW'(16'h4242), LW'(16), 1'b0);
`ifdef SPI_XFER_TIMEOUT_EN
    go_t = -1; rv_t = -1; w = 0;
    while (rv_t < 0 && w < 200) begin
      if (go_t < 0 && sr_go === 1'b1) go_t = w;
      if (rsp_valid === 1'b1) rv_t = w;
      else begin @(negedge clk); w++; end
    end
    chk("to_go_time", 128'(go_t), 128'(1 + SETUP));
    chk("to_rsp_time", 128'(rv_t), 128'(1 + SETUP + TO));
    chk("to_rsp_err", rsp_err, 1'b1);
    chk("to_rsp_data", rsp_data, '0);
    chk("to_ss_n", ss_n, 1'b1);
    chk("to_sr_go", sr_go, 1'b0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    w = 0;
    while (cmd_ready !== 1'b1 && w < 50) begin @(negedge clk); w++; end
    chk("to_gap_cycles", 128'(w), 128'(GAP));
    frame_closed = 1'b1;
`else
    go_t = -1; rv_t = 0;
    for (int i = 0; i < 40; i++) begin
      if (go_t < 0 && sr_go === 1'b1) go_t = i;
      if (rsp_valid === 1'b1) rv_t++;
      @(negedge clk);
    end
    chk("stall_go_time", 128'(go_t), 128'(1 + SETUP));
    chk("stall_sr_go", sr_go, 1'b1);
    chk("stall_no_rsp", 128'(rv_t), 128'(0));
    chk("stall_rsp_err", rsp_err, 1'b0);
    chk("stall_ss_low", ss_n, 1'b0);
    do_reset();
`endif
    slave_en = 1'b1;

    // Randomized command stream.
    for (int n = 0; n < 24; n++) begin
      xfer(rnd_char(), LW'($urandom_range(0, 127)), 1'($urandom_range(0, 2) == 0),
           int'($urandom_range(1, 6)), rnd_char(), int'($urandom_range(0, 4)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
